// File: rtl/clk_div_cfg_initiator.sv
// clk_div_cfg_initiator
// Controller-domain initiator for the clock divider's 4-phase valid/ack
// handshake. Accepts register writes at any time, keeps one pending request
// (latest value wins), bounds every wait with a timeout and reports the value
// the divider last acknowledged.
module clk_div_cfg_initiator #(
    parameter logic [7:0]  DIV_INIT    = 8'h00,
    parameter int unsigned TIMEOUT     = 255,  // 0 disables timeouts
    parameter int unsigned SYNC_STAGES = 2     // must be at least 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cfg_req_i,
    input  logic [7:0] cfg_div_i,
    output logic       cfg_done_o,
    output logic       cfg_err_o,
    output logic       busy_o,
    output logic [7:0] cur_div_o,
    output logic [7:0] clk_div_data_o,
    output logic       clk_div_valid_o,
    input  logic       clk_div_ack_i
);

    // Counter is wide enough to hold TIMEOUT; kept at one bit when disabled.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Value seen on the last permitted cycle of a wait state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;  // waiting for a request
    localparam logic [1:0] S_REQ  = 2'd1;  // valid high, waiting for ack
    localparam logic [1:0] S_REL  = 2'd2;  // valid low, waiting for ack release

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ok;
    logic                   r_pend_vld;
    logic [7:0]             r_pend_div;
    logic [7:0]             r_data;
    logic [7:0]             r_cur;
    logic                   r_valid;
    logic                   r_done;
    logic                   r_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic       w_ack_s;
    logic       w_exit;
    logic       w_timeout;
    logic       w_launch;
    logic [7:0] w_launch_div;
    logic [1:0] w_state_nxt;
    logic       w_cnt_clr;
    logic       w_ok_load;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic       w_cur_load;

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // Exit condition of the current wait state: ack high in REQ, ack low in REL.
    assign w_exit = (r_state == S_REQ) ? w_ack_s : ~w_ack_s;

    // Fires on the last allowed cycle of a wait state if it is still waiting.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST) && !w_exit;

    // A launch needs the previous handshake fully released on the divider side.
    assign w_launch     = (r_state == S_IDLE) && (cfg_req_i || r_pend_vld) && !w_ack_s;
    // A request arriving in the launch cycle is newer than the slot contents.
    assign w_launch_div = cfg_req_i ? cfg_div_i : r_pend_div;

    // Ack synchronizer: only the last stage is ever looked at.
    always_ff @(posedge clk_i) begin
        // NOTE: every clocked register uses <= so all stages sample the
        // pre-edge values; blocking assignments would collapse the chain.
        if (rst_i) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], clk_div_ack_i};
        end
    end

    // Next-state and event decode for the handshake FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_ok_load   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cur_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_REQ;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_REQ: begin
                if (w_ack_s || w_timeout) begin
                    w_state_nxt = S_REL;
                    w_cnt_clr   = 1'b1;
                    w_ok_load   = 1'b1;
                end
            end
            S_REL: begin
                if (!w_ack_s) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = r_ok;
                    w_err_nxt   = ~r_ok;
                    w_cur_load  = r_ok;
                end else if (w_timeout) begin
                    // Ack stuck high: the divider never confirmed release,
                    // so the value is not treated as committed.
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, result flag, wait counter and registered status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ok    <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Valid is simply "next state is REQ", so it rises at launch and
            // drops on the same edge that leaves REQ.
            r_valid <= (w_state_nxt == S_REQ);
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_ok_load) begin
                r_ok <= w_ack_s;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if ((r_state != S_IDLE) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Pending-slot valid flag: set by any non-launching write, cleared at launch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_vld <= 1'b0;
        end else if (w_launch) begin
            r_pend_vld <= 1'b0;
        end else if (cfg_req_i) begin
            r_pend_vld <= 1'b1;
        end
    end

    // Pending-slot data: latest write wins.
    always_ff @(posedge clk_i) begin
        // NOTE: no reset here; the value is only ever used while r_pend_vld
        // is set, and that flag is reset.
        if (cfg_req_i && !w_launch) begin
            r_pend_div <= cfg_div_i;
        end
    end

    // Divider data changes only at launch; committed value only on a clean done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= DIV_INIT;
            r_cur  <= DIV_INIT;
        end else begin
            if (w_launch) begin
                r_data <= w_launch_div;
            end
            if (w_cur_load) begin
                r_cur <= r_data;
            end
        end
    end

    assign cfg_done_o      = r_done;
    assign cfg_err_o       = r_err;
    assign busy_o          = (r_state != S_IDLE) || r_pend_vld;
    assign cur_div_o       = r_cur;
    assign clk_div_data_o  = r_data;
    assign clk_div_valid_o = r_valid;

endmodule

// File: tb/tb_clk_div_cfg_initiator.sv
// tb_clk_div_cfg_initiator
// Directed bench for clk_div_cfg_initiator: a table of single-write handshakes
// against a programmable responder, plus hand-written multi-cycle sequences.
module tb_clk_div_cfg_initiator;

    localparam logic [7:0] DIV_INIT = 8'h3C;
    localparam int         TIMEOUT  = 16;

    logic       clk;
    logic       rst_i;
    logic       cfg_req_i;
    logic [7:0] cfg_div_i;
    logic       cfg_done_o;
    logic       cfg_err_o;
    logic       busy_o;
    logic [7:0] cur_div_o;
    logic [7:0] clk_div_data_o;
    logic       clk_div_valid_o;
    logic       clk_div_ack_i;

    clk_div_cfg_initiator #(
        .DIV_INIT    (DIV_INIT),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .cfg_req_i       (cfg_req_i),
        .cfg_div_i       (cfg_div_i),
        .cfg_done_o      (cfg_done_o),
        .cfg_err_o       (cfg_err_o),
        .busy_o          (busy_o),
        .cur_div_o       (cur_div_o),
        .clk_div_data_o  (clk_div_data_o),
        .clk_div_valid_o (clk_div_valid_o),
        .clk_div_ack_i   (clk_div_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- responder ----------------
    // ack_dly: cycles of observed valid before raising ack (0 = never)
    // rel_dly: cycles of observed valid-low before dropping ack
    // stuck:   keep ack high regardless of valid
    int resp_ack_dly = 1;
    int resp_rel_dly = 1;
    bit resp_stuck   = 1'b0;

    initial begin
        int rcnt;
        rcnt = 0;
        clk_div_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!clk_div_ack_i) begin
                if (clk_div_valid_o && resp_ack_dly > 0) begin
                    rcnt++;
                    if (rcnt >= resp_ack_dly) begin
                        clk_div_ack_i = 1'b1;
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
            end else begin
                if (!clk_div_valid_o && !resp_stuck) begin
                    rcnt++;
                    if (rcnt >= resp_rel_dly) begin
                        clk_div_ack_i = 1'b0;
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
            end
        end
    end

    // ---------------- monitor (samples 1 time unit after the edge) ----------------
    int         mon_done = 0;
    int         mon_err  = 0;
    int         mon_both = 0;
    int         mon_vcyc = 0;
    int         mon_unstable = 0;
    int         mon_rel_len = 0;
    int         cyc = 0;
    int         t_fall = 0;
    logic [7:0] sent[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_i) begin
            if (cfg_done_o) mon_done++;
            if (cfg_err_o) mon_err++;
            if (cfg_done_o && cfg_err_o) mon_both++;
            if (clk_div_valid_o) mon_vcyc++;
            if (clk_div_valid_o && !prev_valid) sent.push_back(clk_div_data_o);
            if (clk_div_valid_o && prev_valid && clk_div_data_o != prev_data) mon_unstable++;
            if (!clk_div_valid_o && prev_valid) t_fall = cyc;
            if (cfg_done_o || cfg_err_o) mon_rel_len = cyc - t_fall;
        end
        prev_valid = clk_div_valid_o;
        prev_data  = clk_div_data_o;
    end

    task automatic clear_mon();
        mon_done = 0;
        mon_err  = 0;
        mon_vcyc = 0;
        mon_rel_len = 0;
        sent.delete();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy_o && k < 300) begin
            step();
            k++;
        end
        check({name, "_idle"}, busy_o, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] div;
        int         ack_dly;
        int         rel_dly;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_cur;
        int         exp_vcyc;
    } vec_t;

    vec_t vecs [7];

    // Global time bound in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // div, ack_dly, rel_dly, done, err, cur, valid-high cycles
        vecs[0] = '{8'h05,  3, 3, 1, 0, 8'h05,  5};
        vecs[1] = '{8'hA7,  1, 1, 1, 0, 8'hA7,  3};
        vecs[2] = '{8'hFF,  5, 2, 1, 0, 8'hFF,  7};
        vecs[3] = '{8'h00,  0, 1, 0, 1, 8'hFF, 16};  // silent responder
        vecs[4] = '{8'h81, 14, 2, 1, 0, 8'h81, 16};  // ack in last allowed cycle
        vecs[5] = '{8'h42, 15, 2, 0, 1, 8'h81, 16};  // ack one cycle too late
        vecs[6] = '{8'h42,  2, 4, 1, 0, 8'h42,  4};

        // ---- reset state ----
        rst_i     = 1'b1;
        cfg_req_i = 1'b0;
        cfg_div_i = 8'h00;
        repeat (3) step();
        check("rst_valid", clk_div_valid_o, 0);
        check("rst_done",  cfg_done_o, 0);
        check("rst_err",   cfg_err_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_data",  clk_div_data_o, DIV_INIT);
        check("rst_cur",   cur_div_o, DIV_INIT);
        rst_i = 1'b0;
        repeat (2) step();

        // ---- table-driven single writes ----
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            resp_ack_dly = vecs[i].ack_dly;
            resp_rel_dly = vecs[i].rel_dly;
            resp_stuck   = 1'b0;
            cfg_req_i = 1'b1;
            cfg_div_i = vecs[i].div;
            step();
            cfg_req_i = 1'b0;
            check($sformatf("v%0d_valid_n1", i), clk_div_valid_o, 1);
            check($sformatf("v%0d_data_n1", i), clk_div_data_o, vecs[i].div);
            wait_idle($sformatf("v%0d", i));
            repeat (4) step();
            check($sformatf("v%0d_done", i), mon_done, vecs[i].exp_done);
            check($sformatf("v%0d_err", i), mon_err, vecs[i].exp_err);
            check($sformatf("v%0d_cur", i), cur_div_o, vecs[i].exp_cur);
            check($sformatf("v%0d_vcyc", i), mon_vcyc, vecs[i].exp_vcyc);
        end

        // ---- three requests while busy: latest wins ----
        clear_mon();
        resp_ack_dly = 3;
        resp_rel_dly = 3;
        cfg_req_i = 1'b1; cfg_div_i = 8'h11; step();
        cfg_req_i = 1'b0; step();
        cfg_req_i = 1'b1; cfg_div_i = 8'h10; step();
        cfg_div_i = 8'h20; step();
        cfg_div_i = 8'h30; step();
        cfg_req_i = 1'b0;
        wait_idle("lw");
        repeat (4) step();
        check("lw_done_cnt", mon_done, 2);
        check("lw_sent_cnt", sent.size(), 2);
        if (sent.size() == 2) begin
            check("lw_sent0", sent[0], 8'h11);
            check("lw_sent1", sent[1], 8'h30);
        end
        check("lw_cur", cur_div_o, 8'h30);
        check("lw_busy", busy_o, 0);

        // ---- request in the cycle the handshake finishes ----
        clear_mon();
        resp_ack_dly = 1;
        resp_rel_dly = 1;
        cfg_req_i = 1'b1; cfg_div_i = 8'h99; step();   // cycle N
        cfg_req_i = 1'b0;
        repeat (5) step();                              // reach cycle N+6 (REL exit)
        cfg_req_i = 1'b1; cfg_div_i = 8'h9A; step();   // cycle N+7
        cfg_req_i = 1'b0;
        check("fin_done_n7", cfg_done_o, 1);
        check("fin_cur_n7", cur_div_o, 8'h99);
        check("fin_valid_n7", clk_div_valid_o, 0);
        check("fin_busy_n7", busy_o, 1);
        step();                                         // cycle N+8
        check("fin_valid_n8", clk_div_valid_o, 1);
        check("fin_data_n8", clk_div_data_o, 8'h9A);
        wait_idle("fin");
        repeat (4) step();
        check("fin_cur", cur_div_o, 8'h9A);
        check("fin_done_cnt", mon_done, 2);

        // ---- ack stuck high in REL, then a held request ----
        clear_mon();
        resp_ack_dly = 2;
        resp_rel_dly = 1;
        resp_stuck   = 1'b1;
        cfg_req_i = 1'b1; cfg_div_i = 8'h55; step();
        cfg_req_i = 1'b0;
        begin
            int k;
            k = 0;
            while (mon_err == 0 && k < 100) begin
                step();
                k++;
            end
        end
        check("stk_err_cnt", mon_err, 1);
        check("stk_rel_len", mon_rel_len, TIMEOUT);
        check("stk_done_cnt", mon_done, 0);
        check("stk_cur", cur_div_o, 8'h9A);
        step();
        cfg_req_i = 1'b1; cfg_div_i = 8'h66; step();
        cfg_req_i = 1'b0;
        repeat (5) step();
        check("stk_hold_busy", busy_o, 1);
        check("stk_hold_valid", clk_div_valid_o, 0);
        check("stk_hold_sent", sent.size(), 1);
        resp_stuck = 1'b0;
        wait_idle("stk");
        repeat (4) step();
        check("stk_sent_cnt", sent.size(), 2);
        if (sent.size() == 2) begin
            check("stk_sent1", sent[1], 8'h66);
        end
        check("stk_cur_after", cur_div_o, 8'h66);
        check("stk_done_after", mon_done, 1);
        check("stk_err_after", mon_err, 1);

        // ---- reset while in REQ with a pending request ----
        clear_mon();
        resp_ack_dly = 0;
        cfg_req_i = 1'b1; cfg_div_i = 8'h77; step();
        cfg_req_i = 1'b0;
        repeat (3) step();
        cfg_req_i = 1'b1; cfg_div_i = 8'h78; step();
        cfg_req_i = 1'b0;
        check("rq_valid_pre", clk_div_valid_o, 1);
        rst_i = 1'b1;
        step();
        check("rq_valid", clk_div_valid_o, 0);
        check("rq_busy", busy_o, 0);
        check("rq_data", clk_div_data_o, DIV_INIT);
        check("rq_cur", cur_div_o, DIV_INIT);
        check("rq_done", cfg_done_o, 0);
        check("rq_err", cfg_err_o, 0);
        rst_i = 1'b0;
        repeat (20) step();
        check("rq_done_cnt", mon_done, 0);
        check("rq_err_cnt", mon_err, 0);
        check("rq_sent_cnt", sent.size(), 1);
        check("rq_busy_after", busy_o, 0);

        // ---- whole-run invariants ----
        check("done_err_excl", mon_both, 0);
        check("data_stable", mon_unstable, 0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
        $finish;
    end

endmodule
